// File: rtl/controlador_varredura.sv
// Scan controller for a 4-digit multiplexed display: walks the nibble select through
// the enabled digits, blanks on every digit change and reloads the display word per frame.
module controlador_varredura #(
    parameter int DIV   = 50000,
    parameter int BLANK = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  digit_mask,
    input  logic [15:0] dados_in,
    output logic [15:0] dados_out,
    output logic [1:0]  sel,
    output logic [3:0]  digito_n,
    output logic        frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]    mask_r;
    logic [1:0]    nxt_s;
    logic          wrap_s;

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] r;
        casez (m)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // First enabled index strictly after cur, wrapping; returns cur itself if it is the only one.
    function automatic logic [1:0] next_idx(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return r;
    endfunction

    assign nxt_s  = next_idx(mask_r, sel);
    assign wrap_s = (nxt_s <= sel);

    // Scan state machine with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            mask_r     <= 4'h0;
            sel        <= 2'd0;
            digito_n   <= 4'hF;
            dados_out  <= 16'h0000;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (!enable) begin
                state_r  <= S_IDLE;
                cnt_r    <= '0;
                sel      <= 2'd0;
                digito_n <= 4'hF;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        digito_n <= 4'hF;
                        sel      <= 2'd0;
                        if (digit_mask != 4'h0) begin
                            mask_r    <= digit_mask;
                            dados_out <= dados_in;
                            sel       <= lowest_idx(digit_mask);
                            cnt_r     <= '0;
                            state_r   <= S_BLANK;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_BLANK: begin
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CW'(BLANK - 1)) begin
                            state_r  <= S_SHOW;
                            digito_n <= ~(4'b0001 << sel);
                        end else begin
                            digito_n <= 4'hF;
                        end
                    end
                    S_SHOW: begin
                        if (cnt_r == CW'(DIV - 1)) begin
                            cnt_r    <= '0;
                            digito_n <= 4'hF;
                            if (wrap_s) begin
                                // Frame boundary: the new word and mask take effect together.
                                frame_tick <= 1'b1;
                                dados_out  <= dados_in;
                                mask_r     <= digit_mask;
                                if (digit_mask == 4'h0) begin
                                    state_r <= S_IDLE;
                                    sel     <= 2'd0;
                                end else begin
                                    state_r <= S_BLANK;
                                    sel     <= lowest_idx(digit_mask);
                                end
                            end else begin
                                state_r <= S_BLANK;
                                sel     <= nxt_s;
                            end
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    default: begin
                        state_r  <= S_IDLE;
                        cnt_r    <= '0;
                        sel      <= 2'd0;
                        digito_n <= 4'hF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controlador_varredura.sv
// Directed bench for controlador_varredura with DIV=8, BLANK=2: vector table plus
// hand-written sequences for disable, mask-zero, single-digit and reset corners.
module tb_controlador_varredura;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  digit_mask;
    logic [15:0] dados_in;
    logic [15:0] dados_out;
    logic [1:0]  sel;
    logic [3:0]  digito_n;
    logic        frame_tick;

    int passed;
    int total;

    controlador_varredura #(.DIV(8), .BLANK(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digit_mask (digit_mask),
        .dados_in   (dados_in),
        .dados_out  (dados_out),
        .sel        (sel),
        .digito_n   (digito_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  mask;
        logic [15:0] din;
        int          n;
        logic [1:0]  e_sel;
        logic [3:0]  e_dn;
        logic        e_ft;
        logic [15:0] e_dout;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input logic [1:0] s, input logic [3:0] dn,
                           input logic ft, input logic [15:0] dout);
        chk({nm, ".sel"}, 32'(sel), 32'(s));
        chk({nm, ".digito_n"}, 32'(digito_n), 32'(dn));
        chk({nm, ".frame_tick"}, 32'(frame_tick), 32'(ft));
        chk({nm, ".dados_out"}, 32'(dados_out), 32'(dout));
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        digit_mask = 4'h0;
        dados_in   = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int k;
        passed = 0;
        total  = 0;

        // Edge numbers in comments count posedges since enable first rose.
        tbl[0]  = '{1'b1, 4'hF, 16'h1234, 1,  2'd0, 4'hF, 1'b0, 16'h1234}; // e1 blank
        tbl[1]  = '{1'b1, 4'hF, 16'h1234, 1,  2'd0, 4'hF, 1'b0, 16'h1234}; // e2 blank
        tbl[2]  = '{1'b1, 4'hF, 16'h1234, 1,  2'd0, 4'hE, 1'b0, 16'h1234}; // e3 show d0
        tbl[3]  = '{1'b1, 4'hF, 16'h1234, 5,  2'd0, 4'hE, 1'b0, 16'h1234}; // e8 last show
        tbl[4]  = '{1'b1, 4'hF, 16'h1234, 1,  2'd1, 4'hF, 1'b0, 16'h1234}; // e9 slot 1
        tbl[5]  = '{1'b1, 4'hF, 16'h1234, 2,  2'd1, 4'hD, 1'b0, 16'h1234}; // e11
        tbl[6]  = '{1'b1, 4'hF, 16'h1234, 8,  2'd2, 4'hB, 1'b0, 16'h1234}; // e19
        tbl[7]  = '{1'b1, 4'hF, 16'h1234, 8,  2'd3, 4'h7, 1'b0, 16'h1234}; // e27
        tbl[8]  = '{1'b1, 4'hF, 16'hABCD, 5,  2'd3, 4'h7, 1'b0, 16'h1234}; // e32 no tearing
        tbl[9]  = '{1'b1, 4'hF, 16'hABCD, 1,  2'd0, 4'hF, 1'b1, 16'hABCD}; // e33 frame
        tbl[10] = '{1'b1, 4'hF, 16'hABCD, 1,  2'd0, 4'hF, 1'b0, 16'hABCD}; // e34
        tbl[11] = '{1'b1, 4'hF, 16'hABCD, 31, 2'd0, 4'hF, 1'b1, 16'hABCD}; // e65 frame
        tbl[12] = '{1'b1, 4'hA, 16'hABCD, 1,  2'd0, 4'hF, 1'b0, 16'hABCD}; // e66 mask pending
        tbl[13] = '{1'b1, 4'hA, 16'hABCD, 31, 2'd1, 4'hF, 1'b1, 16'hABCD}; // e97 new mask
        tbl[14] = '{1'b1, 4'hA, 16'hABCD, 2,  2'd1, 4'hD, 1'b0, 16'hABCD}; // e99
        tbl[15] = '{1'b1, 4'hA, 16'hABCD, 6,  2'd3, 4'hF, 1'b0, 16'hABCD}; // e105
        tbl[16] = '{1'b1, 4'hA, 16'hABCD, 2,  2'd3, 4'h7, 1'b0, 16'hABCD}; // e107
        tbl[17] = '{1'b1, 4'hA, 16'hABCD, 6,  2'd1, 4'hF, 1'b1, 16'hABCD}; // e113
        tbl[18] = '{1'b1, 4'hA, 16'hABCD, 16, 2'd1, 4'hF, 1'b1, 16'hABCD}; // e129

        do_reset();
        chk_all("reset", 2'd0, 4'hF, 1'b0, 16'h0000);

        for (int i = 0; i < 19; i++) begin
            enable     = tbl[i].en;
            digit_mask = tbl[i].mask;
            dados_in   = tbl[i].din;
            edges(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_dn, tbl[i].e_ft, tbl[i].e_dout);
        end

        // Mask 1010: digits 0 and 2 must never be lit.
        ok = 1'b1;
        for (int c = 0; c < 32; c++) begin
            edges(1);
            if (digito_n[0] == 1'b0 || digito_n[2] == 1'b0) ok = 1'b0;
        end
        chk("mask1010_no_d0_d2", 32'(ok), 32'd1);

        // Single digit: sel fixed at 2, tick every 8 cycles, 2 blank cycles each slot.
        do_reset();
        enable     = 1'b1;
        digit_mask = 4'b0100;
        dados_in   = 16'h0F0F;
        for (k = 1; k <= 32; k++) begin
            edges(1);
            chk_all($sformatf("single_e%0d", k), 2'd2,
                    (((k - 1) % 8) < 2) ? 4'hF : 4'hB,
                    (k >= 9 && ((k - 1) % 8) == 0) ? 1'b1 : 1'b0, 16'h0F0F);
        end

        // Disable while showing digit 1.
        do_reset();
        enable     = 1'b1;
        digit_mask = 4'hF;
        dados_in   = 16'h1234;
        edges(12);
        chk_all("dis_pre", 2'd1, 4'hD, 1'b0, 16'h1234);
        enable   = 1'b0;
        dados_in = 16'h9999;
        edges(1);
        chk_all("dis_post", 2'd0, 4'hF, 1'b0, 16'h1234);
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            edges(1);
            if (frame_tick !== 1'b0 || digito_n !== 4'hF) ok = 1'b0;
        end
        chk("dis_idle", 32'(ok), 32'd1);

        // Mask cleared before the frame boundary: one final tick, then idle.
        do_reset();
        enable     = 1'b1;
        digit_mask = 4'b0100;
        dados_in   = 16'h1111;
        edges(3);
        chk_all("mz_show", 2'd2, 4'hB, 1'b0, 16'h1111);
        digit_mask = 4'h0;
        dados_in   = 16'h2222;
        edges(6);
        chk_all("mz_bound", 2'd0, 4'hF, 1'b1, 16'h2222);
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            edges(1);
            if (frame_tick !== 1'b0 || digito_n !== 4'hF || sel !== 2'd0) ok = 1'b0;
        end
        chk("mz_idle", 32'(ok), 32'd1);

        // Asynchronous reset while digit 2 is lit, then restart.
        do_reset();
        enable     = 1'b1;
        digit_mask = 4'hF;
        dados_in   = 16'h5555;
        edges(20);
        chk_all("rst_pre", 2'd2, 4'hB, 1'b0, 16'h5555);
        reset = 1'b1;
        #1;
        chk_all("rst_async", 2'd0, 4'hF, 1'b0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        edges(2);
        chk_all("rst_blank", 2'd0, 4'hF, 1'b0, 16'h5555);
        edges(1);
        chk_all("rst_light", 2'd0, 4'hE, 1'b0, 16'h5555);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
